// File: rtl/memory_stage_hs_if.sv
// memory_stage_hs_if: request/grant/response data-memory port.
// The master modport is the MEM stage side, slave is the memory side.
interface memory_stage_hs_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/memory_stage_hs.sv
// memory_stage_hs: RISC-V MEM stage with a variable-latency data port.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module memory_stage_hs #(
    parameter int  ADDR_W  = 32,
    parameter int  TIMEOUT = 16,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ValidM,
    input  logic              MemWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [1:0]        StoreTypeM,
    input  logic [2:0]        LoadTypeM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              ErrM,
    output logic              MisalignM,
    memory_stage_hs_if.master dmem
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rd_q;
    logic [31:0]      ext;
    logic [7:0]       bsel;
    logic [15:0]      hsel;
    logic [1:0]       a;
    logic             ld;
    logic             access;
    logic             trap;
    logic             pending;
    logic             sz_b;
    logic             sz_h;
    logic             rsp;
    logic             tmo;
    logic             done;

    assign a  = ALUResultM[1:0];
    assign ld = !MemWriteM && ResultSrcM == 2'b01;

    // Reserved store type is a no-op, not a load.
    assign access = ValidM && (MemWriteM ? StoreTypeM != 2'b11
                                         : ResultSrcM == 2'b01);

    always_comb begin
        sz_b = 1'b0;
        sz_h = 1'b0;
        if (MemWriteM) begin
            sz_b = StoreTypeM == 2'b00;
            sz_h = StoreTypeM == 2'b01;
        end else begin
            sz_b = LoadTypeM inside {3'b000, 3'b100};
            sz_h = LoadTypeM inside {3'b001, 3'b101};
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic bad_align;
    assign bad_align = sz_h ? a[0] : (!sz_b && a != 2'b00);
    assign trap      = access && bad_align;
    assign pending   = access && !bad_align;
`else
    assign trap    = 1'b0;
    assign pending = access;
`endif

    assign rsp  = state == RESP && dmem.rvalid;
    assign tmo  = state != IDLE && !rsp
               && cnt == CNT_W'(TIMEOUT - 1);
    assign done = rsp || tmo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (pending) state_nx = dmem.gnt ? RESP : REQ;
            REQ: begin
                if (tmo)           state_nx = IDLE;
                else if (dmem.gnt) state_nx = RESP;
            end
            RESP:    if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              cnt <= '0;
        else if (state == IDLE) cnt <= '0;
        else                   cnt <= cnt + CNT_W'(1);
    end

    assign bsel = dmem.rdata[{a, 3'b000} +: 8];
    assign hsel = a[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];

    always_comb begin
        ext = dmem.rdata;
        unique case (1'b1)
            sz_b: ext = {{24{bsel[7] & !LoadTypeM[2]}}, bsel};
            sz_h: ext = {{16{hsel[15] & !LoadTypeM[2]}}, hsel};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        rd_q <= '0;
        else if (ld && rsp)              rd_q <= ext;
        else if (ld && (tmo || trap))    rd_q <= '0;
    end

    always_comb begin
        dmem.req   = 1'b0;
        dmem.we    = MemWriteM;
        dmem.addr  = {ALUResultM[ADDR_W-1:2], 2'b00};
        dmem.be    = 4'b1111;
        dmem.wdata = WriteDataM;
        if (MemWriteM) begin
            unique case (1'b1)
                sz_b: begin
                    dmem.be    = 4'b0001 << a;
                    dmem.wdata = {4{WriteDataM[7:0]}};
                end
                sz_h: begin
                    dmem.be    = 4'b0011 << {a[1], 1'b0};
                    dmem.wdata = {2{WriteDataM[15:0]}};
                end
                default: ;
            endcase
        end
        unique case (state)
            IDLE, REQ: dmem.req = rst && pending && !tmo;
            default:   ;
        endcase
        StallM    = pending && !done;
        ErrM      = tmo;
        MisalignM = rst && trap;
        ReadDataM = rd_q;
        if (ld && rsp)                 ReadDataM = ext;
        else if (ld && (tmo || trap))  ReadDataM = '0;
    end
endmodule
